spe_accumulator: RTL and testbench
==================================

Name: spe_accumulator

Overview:
- Summation PE stage directly downstream of the partial-sum PEs (PPEs).
- Collects one signed partial sum per filter row (FILTER_SIZE sources) for each output pixel this SPE owns, and adds the total to that pixel's membrane potential.
- Thresholds the potential and emits a spike/no-spike result per pixel to the output packetizer.
- Keeps membrane potentials across timesteps. Handles the timestep-done marker.

Parameters:
- FILTER_SIZE, 5, number of PPE sources; one partial sum per source per pixel.
- SPE_ID, 0, index of this SPE, 0..FILTER_SIZE-1; pixels are interleaved across SPEs.
- NUM_PIX, 89, local pixels owned per timestep.
- DEPTH, 4, pending-pixel slots; a source may run at most DEPTH pixels ahead of retirement.
- PSUM_W, 14, signed partial-sum width.
- MEM_W, 18, signed membrane-potential width.
- THRESHOLD, 64, spike threshold; a spike fires when the potential is greater than or equal to THRESHOLD.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  partial sum offered
- in_ready  out  1  partial sum accepted when in_valid&&in_ready at posedge
- in_src  in  3  source PPE id
- in_psum  in  PSUM_W  signed partial sum
- ts_done  in  1  single-cycle timestep-done marker
- out_valid  out  1  result offered
- out_ready  in  1  consumer accepts result
- out_spike  out  1  1 = potential reached THRESHOLD
- out_pixel  out  9  global pixel index = local*FILTER_SIZE+SPE_ID
- ts_ack  out  1  one-cycle pulse when timestep close completes
- ts_count  out  4  completed timesteps
- err_src  out  1  sticky: in_src >= FILTER_SIZE seen
- err_count  out  1  sticky: pixel count mismatch or overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset, asynchronous while rst_n=0, including mid-operation:
  - Cleared: all slots, masks, per-source write pointers, read pointer, pixel counter, membrane array (flops), ts_count, errors.
  - FSM returns to IDLE.
  - Outputs: out_valid=0, out_spike=0, out_pixel=0, ts_ack=0, in_ready=1.
- Slots:
  - Each slot holds acc (signed PSUM_W+3 bits) and mask (FILTER_SIZE bits).
  - Each source s has write pointer wp[s] (mod DEPTH). Its n-th accepted psum belongs to slot n mod DEPTH.
- in_ready:
  - Combinational per in_src: 1 iff mask[wp[in_src]][in_src]==0.
  - A slot being retired this cycle frees no bit until the next cycle (no bypass).
- Accept:
  - acc += sign-extended in_psum; set the mask bit; wp[src]++.
  - A psum whose mask fills the slot contributes in that same edge.
- Invalid source: in_src >= FILTER_SIZE is accepted (in_ready=1), dropped, and sets err_src.
- Retirement FSM:
  - IDLE: if mask[rp] is all ones → READ.
  - READ (1 cycle): sum = mem[pix] + acc, saturated to MEM_W.
    - If sum >= THRESHOLD: spike=1 and mem[pix] := 0.
    - Else: spike=0 and mem[pix] := sum.
    - Clear the slot; rp++ → EMIT.
  - EMIT: out_valid=1 and hold out_spike/out_pixel stable until out_ready. On handshake: pix++ → IDLE.
  - pix wraps NUM_PIX-1 → 0 and sets err_count.
- Latency: the edge that fills a slot is edge N; out_valid is high after edge N+2 if the FSM is IDLE.
- Throughput: one pixel per 3 cycles max (IDLE, READ, EMIT).
- Results are always emitted in slot order regardless of psum arrival order.
- Timestep close:
  - ts_done sets a sticky pending flag; a repeat ts_done while pending is ignored.
  - The FSM enters TSEND from IDLE only when pending=1, all masks are zero, and no accumulation is in flight.
  - TSEND (1 cycle): ts_ack=1, ts_count++ (wraps at 16), wp/rp/pix := 0, pending cleared. If pix != 0 (i.e. not exactly NUM_PIX emitted mod NUM_PIX), err_count is set. Membrane values are retained.
- If ts_done and a slot-filling psum arrive in the same cycle, the slot is retired first.
- A partially filled slot blocks TSEND indefinitely; it is not an error.

Test Plan:
- Single pixel, SPE_ID=2: psums 10,20,5,15,14 from sources 0-4 (sum 64) → out_spike=1, out_pixel=2, 2 cycles after the last accept; mem[0]=0.
- Sub-threshold then carry:
  - psums totalling 40 → spike=0, mem=40.
  - After ts_done: ts_ack, ts_count=1.
  - Next timestep, pixel 0 total 30 → spike=1 (70 ≥ 64), mem=0.
- Out-of-order and backpressure, DEPTH=4:
  - Source 0 sends 5 psums with other sources idle → 5th stalls (in_ready=0) until slot 0 retires.
  - Results come out in pixel order 0,1,2 with out_ready held low 10 cycles; outputs stay stable while held.
- Negative and saturation:
  - psums -8192×5 on an empty mem → mem = -40960 (in range), spike=0.
  - Repeating until below -131072 clamps at -131072.
- Errors: in_src=6 → accepted and dropped, err_src=1. ts_done after 3 pixels with NUM_PIX=89 → err_count=1.
- Reset: assert rst_n low during EMIT → out_valid drops immediately, mem cleared, the next pixel restarts at out_pixel=SPE_ID.

Source files
------------

// File: rtl/spe_accumulator.sv
// Summation PE: gathers one partial sum per filter row for each owned pixel,
// integrates it into a persistent membrane potential and emits spike results.

module spe_slot #(
  parameter int FILTER_SIZE = 5,
  parameter int PSUM_W      = 14,
  parameter int ACC_W       = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     add_en,
  input  logic [2:0]               add_src,
  input  logic signed [PSUM_W-1:0] add_psum,
  input  logic                     clr,
  output logic signed [ACC_W-1:0]  acc,
  output logic [FILTER_SIZE-1:0]   mask
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mask <= '0;
    end else if (clr) begin
      acc  <= '0;
      mask <= '0;
    end else if (add_en) begin
      acc           <= acc + ACC_W'(add_psum);
      mask[add_src] <= 1'b1;
    end
  end
endmodule

module spe_accumulator #(
  parameter int FILTER_SIZE = 5,
  parameter int SPE_ID      = 0,
  parameter int NUM_PIX     = 89,
  parameter int DEPTH       = 4,
  parameter int PSUM_W      = 14,
  parameter int MEM_W       = 18,
  parameter int THRESHOLD   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_src,
  input  logic [PSUM_W-1:0] in_psum,
  input  logic              ts_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_spike,
  output logic [8:0]        out_pixel,
  output logic              ts_ack,
  output logic [3:0]        ts_count,
  output logic              err_src,
  output logic              err_count
);
  localparam int ACC_W = PSUM_W + 3;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [2:0]              FS3  = 3'(FILTER_SIZE);
  localparam logic signed [MEM_W:0]   SMAX = (MEM_W+1)'((2**(MEM_W-1)) - 1);
  localparam logic signed [MEM_W:0]   SMIN = (MEM_W+1)'(-(2**(MEM_W-1)));
  localparam logic signed [MEM_W-1:0] THR  = MEM_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, READ, EMIT, TSEND} state_t;
  state_t state, state_nxt;

  logic [FILTER_SIZE-1:0][PW-1:0]    wp;
  logic [PW-1:0]                     rp;
  logic [XW-1:0]                     pix;
  logic [DEPTH-1:0][FILTER_SIZE-1:0] slot_mask;
  logic signed [ACC_W-1:0]           slot_acc [DEPTH];
  logic signed [MEM_W-1:0]           mem [NUM_PIX];
  logic                              pending;

  logic                    src_ok, acc_en, full_rp, all_empty, spike_nxt;
  logic [2:0]              src;
  logic [PW-1:0]           tgt;
  logic signed [MEM_W:0]   sum_raw;
  logic signed [MEM_W-1:0] sum_sat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // TSEND rewinds the pointers, so a psum landing that cycle goes to slot 0
  assign src_ok   = in_src < FS3;
  assign src      = src_ok ? in_src : 3'd0;
  assign tgt      = (state == TSEND) ? '0 : wp[src];
  assign in_ready = !src_ok || !slot_mask[tgt][src];
  assign acc_en   = in_valid && in_ready && src_ok;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    spe_slot #(.FILTER_SIZE(FILTER_SIZE), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .add_en   (acc_en && (tgt == PW'(g))),
      .add_src  (src),
      .add_psum (in_psum),
      .clr      ((state == READ) && (rp == PW'(g))),
      .acc      (slot_acc[g]),
      .mask     (slot_mask[g])
    );
  end

  assign full_rp   = &slot_mask[rp];
  assign all_empty = ~|slot_mask;
  assign sum_raw   = (MEM_W+1)'(mem[pix]) + (MEM_W+1)'(slot_acc[rp]);
  assign sum_sat   = (sum_raw > SMAX) ? SMAX[MEM_W-1:0] :
                     (sum_raw < SMIN) ? SMIN[MEM_W-1:0] : sum_raw[MEM_W-1:0];
  assign spike_nxt = sum_sat >= THR;
  assign out_valid = state == EMIT;
  assign ts_ack    = state == TSEND;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (full_rp) state_nxt = READ;
             else if (pending && all_empty && !acc_en) state_nxt = TSEND;
      READ:  state_nxt = EMIT;
      EMIT:  if (out_ready) state_nxt = IDLE;
      TSEND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      pix       <= '0;
      pending   <= 1'b0;
      out_spike <= 1'b0;
      out_pixel <= '0;
      ts_count  <= '0;
      err_src   <= 1'b0;
      err_count <= 1'b0;
    end else begin
      state <= state_nxt;
      for (int s = 0; s < FILTER_SIZE; s++) begin
        if (acc_en && src == 3'(s)) wp[s] <= ptr_inc(tgt);
        else if (state == TSEND)    wp[s] <= '0;
      end
      if (state == TSEND) pending <= 1'b0;
      else if (ts_done)   pending <= 1'b1;
      if (in_valid && !src_ok) err_src <= 1'b1;
      case (state)
        READ: begin
          out_spike <= spike_nxt;
          out_pixel <= 9'(pix) * 9'(FILTER_SIZE) + 9'(SPE_ID);
          rp        <= ptr_inc(rp);
        end
        EMIT: if (out_ready) begin
          if (pix == XW'(NUM_PIX-1)) begin
            pix       <= '0;
            err_count <= 1'b1;
          end else begin
            pix <= pix + XW'(1);
          end
        end
        TSEND: begin
          ts_count <= ts_count + 4'd1;
          rp       <= '0;
          pix      <= '0;
          if (pix != '0) err_count <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Membrane potentials persist across timesteps; a spike resets the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIX; i++) mem[i] <= '0;
    end else if (state == READ) begin
      mem[pix] <= spike_nxt ? '0 : sum_sat;
    end
  end
endmodule

// File: tb/tb_spe_accumulator.sv
// Randomized bench for spe_accumulator against a per-pixel membrane model.
module tb_spe_accumulator;
  localparam int FS = 5, SID = 2, NP = 89, DEP = 4, PW = 14, MW = 18, THR = 64;
  localparam int MAXV = 131071, MINV = -131072;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, ts_done = 1'b0, out_ready = 1'b0;
  logic [2:0]    in_src = '0;
  logic [PW-1:0] in_psum = '0;
  logic          in_ready, out_valid, out_spike, ts_ack, err_src, err_count;
  logic [8:0]    out_pixel;
  logic [3:0]    ts_count;

  int checks = 0, failures = 0;
  int ref_mem [NP];
  int ref_pix = 0;

  spe_accumulator #(.FILTER_SIZE(FS), .SPE_ID(SID), .NUM_PIX(NP), .DEPTH(DEP),
                    .PSUM_W(PW), .MEM_W(MW), .THRESHOLD(THR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_psum(in_psum), .ts_done(ts_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .out_pixel(out_pixel), .ts_ack(ts_ack), .ts_count(ts_count),
    .err_src(err_src), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: potential += total, clamp to MEM_W, spike and reset at THR
  function automatic void model_pix(input int total, output logic sp, output logic [8:0] px);
    int s;
    s = ref_mem[ref_pix] + total;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    sp = (s >= THR);
    ref_mem[ref_pix] = sp ? 0 : s;
    px = 9'(ref_pix * FS + SID);
    ref_pix = (ref_pix + 1) % NP;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; ts_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NP; i++) ref_mem[i] = 0;
    ref_pix = 0;
  endtask

  task automatic send(input int src, input int psum);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_src = 3'(src); in_psum = PW'(psum);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: src=%0d never ready, required ready within 300 cycles", src);
    end
  endtask

  task automatic send_pixel(input int p [5]);
    int ord [5];
    int j, t;
    for (int i = 0; i < 5; i++) ord[i] = i;
    for (int i = 4; i > 0; i--) begin
      j = $urandom_range(i, 0); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 5; i++) send(ord[i], p[ord[i]]);
  endtask

  task automatic rand_split(input int total, output int p [5]);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      p[i] = int'($urandom_range(60, 0)) - 30;
      acc += p[i];
    end
    p[4] = total - acc;
  endtask

  task automatic get_out(input int hold, output logic sp, output logic [8:0] px, output bit stable);
    bit got;
    got = 0; stable = 1; out_ready = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    sp = out_spike; px = out_pixel;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid || out_spike !== sp || out_pixel !== px) stable = 0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    if (!got) begin
      failures++;
      $display("FAIL out_timeout: out_valid=0, required 1 within 300 cycles");
    end
  endtask

  task automatic ts_close();
    bit ok;
    ok = 0;
    ts_done = 1'b1;
    @(posedge clk); #1 ts_done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ts_ack) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ref_pix = 0;
    if (!ok) begin
      failures++;
      $display("FAIL ts_ack_timeout: ts_ack never pulsed, required within 100 cycles");
    end
  endtask

  task automatic test_reset();
    do_reset();
    in_src = 3'd0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_spike !== 1'b0) begin failures++; $display("FAIL rst_out_spike: got %b want 0", out_spike); end
    checks++; if (out_pixel !== 9'd0) begin failures++; $display("FAIL rst_out_pixel: got %0d want 0", out_pixel); end
    checks++; if (ts_ack !== 1'b0)    begin failures++; $display("FAIL rst_ts_ack: got %b want 0", ts_ack); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (ts_count !== 4'd0)  begin failures++; $display("FAIL rst_ts_count: got %0d want 0", ts_count); end
    checks++; if ({err_src, err_count} !== 2'b00) begin failures++; $display("FAIL rst_errors: got %b want 00", {err_src, err_count}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_pixel();
    int p [5];
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    p = '{10, 20, 5, 15, 14};
    send_pixel(p);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_n: out_valid=%b want 0 at fill edge", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_n1: out_valid=%b want 0 after edge N+1", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_n2: out_valid=%b want 1 after edge N+2", out_valid); end
    get_out(0, sp, px, st);
    model_pix(64, esp, epx);
    checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL single: spike/pix %b/%0d want %b/%0d", sp, px, esp, epx); end
    ts_close();
    checks++; if (ts_count !== 4'd1) begin failures++; $display("FAIL single_tscnt: got %0d want 1", ts_count); end
    checks++; if (err_count !== 1'b1) begin failures++; $display("FAIL single_errcnt: got %b want 1 (1 of 89 pixels)", err_count); end
    rand_split(63, p);
    send_pixel(p);
    get_out(0, sp, px, st);
    model_pix(63, esp, epx);
    checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL single_memzero: spike/pix %b/%0d want %b/%0d", sp, px, esp, epx); end
  endtask

  task automatic test_carry();
    int p [5];
    int totals [3];
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    totals = '{40, 30, 30};
    for (int r = 0; r < 3; r++) begin
      rand_split(totals[r], p);
      send_pixel(p);
      get_out(0, sp, px, st);
      model_pix(totals[r], esp, epx);
      checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL carry_r%0d: spike/pix %b/%0d want %b/%0d", r, sp, px, esp, epx); end
      ts_close();
      checks++; if (ts_count !== 4'(r + 1)) begin failures++; $display("FAIL carry_tscnt%0d: got %0d want %0d", r, ts_count, r + 1); end
    end
  endtask

  task automatic test_backpressure();
    int tot [5];
    int cnt [5];
    int v, s, remaining;
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    for (int k = 0; k < 5; k++) begin tot[k] = 0; cnt[k] = 0; end
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(40, 0)) - 10; tot[k] += v; send(0, v);
    end
    in_valid = 1'b1; in_src = 3'd0; in_psum = '0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall: in_ready=%b want 0 for 5th psum", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    remaining = 12;
    while (remaining > 0) begin
      s = $urandom_range(4, 1);
      if (cnt[s] < 3) begin
        v = int'($urandom_range(40, 0)) - 10; tot[cnt[s]] += v;
        send(s, v); cnt[s]++; remaining--;
      end
    end
    repeat (3) @(posedge clk);
    in_src = 3'd0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: in_ready=%b want 1 after slot 0 retired", in_ready); end
    @(posedge clk); #1;
    v = int'($urandom_range(40, 0)) - 10; tot[4] += v; send(0, v);
    for (int k = 0; k < 3; k++) begin
      get_out(10, sp, px, st);
      model_pix(tot[k], esp, epx);
      checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL bp_order%0d: spike/pix %b/%0d want %b/%0d", k, sp, px, esp, epx); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL bp_stable%0d: outputs changed while held, want stable", k); end
    end
    for (int k = 3; k < 5; k++)
      for (int q = 1; q < 5; q++) begin
        v = int'($urandom_range(40, 0)) - 10; tot[k] += v; send(q, v);
      end
    for (int k = 3; k < 5; k++) begin
      get_out(0, sp, px, st);
      model_pix(tot[k], esp, epx);
      checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL bp_tail%0d: spike/pix %b/%0d want %b/%0d", k, sp, px, esp, epx); end
    end
  endtask

  task automatic test_saturation();
    int p [5];
    int t;
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      t = (r < 4) ? -8192 : 8191;
      p = '{t, t, t, t, t};
      send_pixel(p);
      get_out(0, sp, px, st);
      model_pix(5 * t, esp, epx);
      checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL sat_r%0d: spike/pix %b/%0d want %b/%0d", r, sp, px, esp, epx); end
      ts_close();
    end
  endtask

  task automatic test_errors();
    int p [5];
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    in_valid = 1'b1; in_src = 3'd6; in_psum = PW'(100);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL err_src_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (err_src !== 1'b1) begin failures++; $display("FAIL err_src_flag: got %b want 1", err_src); end
    for (int k = 0; k < 3; k++) begin
      rand_split(k == 0 ? 10 : int'($urandom_range(120, 0)), p);
      send_pixel(p);
      get_out(0, sp, px, st);
      model_pix(p[0] + p[1] + p[2] + p[3] + p[4], esp, epx);
      checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL err_pix%0d: spike/pix %b/%0d want %b/%0d", k, sp, px, esp, epx); end
    end
    checks++; if (err_count !== 1'b0) begin failures++; $display("FAIL err_cnt_early: got %b want 0", err_count); end
    ts_close();
    checks++; if (err_count !== 1'b1) begin failures++; $display("FAIL err_cnt_short: got %b want 1", err_count); end
  endtask

  task automatic test_reset_mid();
    int p [5];
    bit got;
    logic sp, esp; logic [8:0] px, epx; bit st;
    do_reset();
    rand_split(40, p);
    send_pixel(p);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    checks++; if (!got) begin failures++; $display("FAIL rmid_emit: out_valid=0 want 1 before reset"); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pixel !== 9'd0) begin failures++; $display("FAIL rmid_async: valid/pix %b/%0d want 0/0", out_valid, out_pixel); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < NP; i++) ref_mem[i] = 0;
    ref_pix = 0;
    rand_split(30, p);
    send_pixel(p);
    get_out(0, sp, px, st);
    model_pix(30, esp, epx);
    checks++; if (sp !== esp || px !== epx) begin failures++; $display("FAIL rmid_restart: spike/pix %b/%0d want %b/%0d", sp, px, esp, epx); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_carry();
    test_backpressure();
    test_saturation();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
